highlight_multi: RTL and testbench
==================================

Name: highlight_multi

Overview:
Parametrised successor lane highlighter. After `hough_done`, draws up to NUM_LANES Hough lines (rho, theta) into a cleared frame BRAM. Each lane has its own valid bit and colour, and line thickness is a parameter. The finished frame is then streamed pixel-by-pixel into the downstream highlight FIFO. It sits between the hough block and the output/overlay FIFO.

Parameters:
NUM_LANES, 2, number of lane inputs drawn in ascending index order
WIDTH, 640, frame width in pixels
HEIGHT, 360, frame height in pixels
PIXEL_BITS, 8, BRAM/FIFO pixel width
THETA_BITS, 9, theta index width (valid range 0..179)
TRIG_DATA_SIZE, 12, signed trig table entry width
BITS, 8, fractional bits of trig tables (Q-format)
K_START, -1000, first line-parameter k (inclusive)
K_END, 1000, last line-parameter k (exclusive)
HALF_WIDTH, 8, line drawn from x-HALF_WIDTH to x+HALF_WIDTH inclusive
SIN_QUANTIZED / COS_QUANTIZED, all 0, signed [0:179] trig tables

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
hough_done  in  1  pulse: lane inputs are valid
lane_rho  in  NUM_LANES x 16 signed  rho per lane
lane_theta  in  NUM_LANES x THETA_BITS  theta per lane
lane_valid  in  NUM_LANES  1 = draw this lane
lane_color  in  NUM_LANES x PIXEL_BITS  pixel value per lane
bram_wr_en / bram_wr_addr / bram_wr_data  out  1 / A / PIXEL_BITS  frame write port; A = $clog2(WIDTH*HEIGHT)
bram_rd_addr  out  A  frame read address
bram_rd_data  in  PIXEL_BITS  read data, 1-cycle latency
highlight_din  out  PIXEL_BITS  FIFO data
highlight_wr_en  out  1  FIFO write
highlight_full  in  1  FIFO full
busy  out  1  high in every state except IDLE
frame_done  out  1  1-cycle pulse on the final FIFO write

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = CLEAR; all counters = 0; pending = 0.
  - All outputs 0, except busy = 1.
- Inputs are latched into registers on the IDLE-to-LANE_SELECT transition. Later input changes are ignored until the next frame.
- hough_done while not IDLE sets `pending`. Entering IDLE with pending = 1 proceeds as if hough_done were seen, then clears pending. Multiple pulses collapse into one.
- CLEAR:
  - Writes 0 to addresses 0..WIDTH*HEIGHT-1, one per cycle: WIDTH*HEIGHT cycles.
  - Then goes to IDLE.
- LANE_SELECT:
  - Scans lane index i from 0, one lane per cycle.
  - Skips a lane if lane_valid[i] = 0 or theta > 179.
  - Otherwise loads sin/cos/rho/colour, sets k = K_START and goes to K_CALC.
  - After the last lane, goes to OUTPUT with pointer = 0 and prime = 1.
- K_CALC:
  - If k >= K_END, goes to LANE_SELECT with i+1.
  - Otherwise computes x = DQ(rho*cos - k*sin) and y = DQ(rho*sin + k*cos), then goes to CHECK.
  - Products are full-width signed 32-bit.
  - DQ = shift right by BITS, truncating toward zero (negate, shift, negate for negative values); result is signed 16-bit.
- CHECK:
  - If 0 <= y < HEIGHT and x+HALF_WIDTH >= 0 and x-HALF_WIDTH < WIDTH, sets off = x-HALF_WIDTH and goes to PIXEL.
  - Otherwise k+1 and back to K_CALC.
- PIXEL:
  - Each cycle, if 0 <= off < WIDTH, writes the colour at y*WIDTH+off.
  - Out-of-range columns are skipped, but the cycle is still spent.
  - off+1 each cycle; after off = x+HALF_WIDTH, k+1 and back to K_CALC.
  - Exactly 2*HALF_WIDTH+1 cycles per accepted k.
- Overlap: a later write overwrites an earlier one (higher lane index wins).
- OUTPUT:
  - bram_rd_addr = next pointer (combinational), so bram_rd_data always matches the registered pointer.
  - Prime cycle: presents address 0; no write.
  - Afterwards, when highlight_full = 0: wr_en = 1, din = rd_data, pointer+1.
  - When highlight_full = 1: no write; address held; data stable.
  - The final pixel (WIDTH*HEIGHT-1) goes through LAST, which writes it when not full, pulses frame_done, and goes to CLEAR.
- No valid lanes: the frame streams all zeros.
- Widths: x/y/off are signed 16-bit; no wrap is possible within the range checks.

Optional Feature:
HIGHLIGHT_PIXEL_CNT_EN:
- When defined: adds output `pixels_drawn` (32-bit) = count of bram_wr_en cycles outside CLEAR in the current frame. It is cleared on entry to LANE_SELECT and holds its value through OUTPUT. Reset value 0.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
Common setup for 1-3: WIDTH=16, HEIGHT=8, HALF_WIDTH=1, K=-8..8, COS[0]=256, SIN[0]=0.
1. Reset release -> 128 CLEAR writes of 0, busy = 1, then IDLE with busy = 0.
2. Lane0 valid, theta=0, rho=5, colour=0xFF; lane1 invalid; hough_done -> stream of 128 pixels; columns 4-6 = 0xFF in all rows, all other pixels 0; one frame_done pulse.
3. Lane0 rho=5 colour 0x11, lane1 rho=6 colour 0x22, both theta=0 -> column 4 = 0x11, columns 5-7 = 0x22.
4. Lane0 rho=0, theta=0 (x=0) -> column 15 untouched; column 0 pixels coloured; column -1 write suppressed.
5. Toggle highlight_full 1/0 randomly during OUTPUT -> FIFO receives exactly WIDTH*HEIGHT pixels, in order, none duplicated or lost.
6. hough_done pulsed during CLEAR, and reset_n asserted mid-PIXEL -> pending frame is drawn after CLEAR; the reset restarts CLEAR with outputs zero.

Source files
------------

// File: rtl/highlight_multi.sv
// highlight_multi
//   Draws up to NUM_LANES Hough lines (rho, theta) into a cleared frame BRAM
//   after hough_done, then streams the finished frame into the highlight FIFO.
//   Sequence per frame: CLEAR -> IDLE -> LANE_SELECT/K_CALC/CHECK/PIXEL
//   -> OUTPUT -> LAST -> CLEAR.
//
// Optional feature (define HIGHLIGHT_PIXEL_CNT_EN):
//   adds output pixels_drawn, the number of frame writes made while drawing
//   the current frame. It is cleared when drawing starts. Without the macro,
//   the port and the counter are absent.
//
// Ports:
//   clock            sole clock
//   reset_n          asynchronous active-low reset
//   hough_done       pulse: lane_* inputs are valid
//   lane_rho         per-lane signed rho (16 bit)
//   lane_theta       per-lane theta index (0..179 valid)
//   lane_valid       per-lane draw enable
//   lane_color       per-lane pixel value
//   bram_wr_en/addr/data  frame write port (registered)
//   bram_rd_addr     frame read address (combinational)
//   bram_rd_data     frame read data, one cycle latency
//   highlight_din/highlight_wr_en  FIFO write port
//   highlight_full   FIFO full
//   busy             high in every state except IDLE
//   frame_done       one-cycle pulse on the final FIFO write
//   pixels_drawn     (HIGHLIGHT_PIXEL_CNT_EN only) draw-write count
module highlight_multi #(
  parameter int NUM_LANES      = 2,
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 360,
  parameter int PIXEL_BITS     = 8,
  parameter int THETA_BITS     = 9,
  parameter int TRIG_DATA_SIZE = 12,
  parameter int BITS           = 8,
  parameter int K_START        = -1000,
  parameter int K_END          = 1000,
  parameter int HALF_WIDTH     = 8,
  parameter logic signed [TRIG_DATA_SIZE-1:0] SIN_QUANTIZED [0:179] = '{default: '0},
  parameter logic signed [TRIG_DATA_SIZE-1:0] COS_QUANTIZED [0:179] = '{default: '0},
  localparam int NPIX = WIDTH * HEIGHT,
  localparam int A    = $clog2(NPIX)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 hough_done,
  input  logic [NUM_LANES-1:0][15:0]           lane_rho,
  input  logic [NUM_LANES-1:0][THETA_BITS-1:0] lane_theta,
  input  logic [NUM_LANES-1:0]                 lane_valid,
  input  logic [NUM_LANES-1:0][PIXEL_BITS-1:0] lane_color,
  output logic                                 bram_wr_en,
  output logic [A-1:0]                         bram_wr_addr,
  output logic [PIXEL_BITS-1:0]                bram_wr_data,
  output logic [A-1:0]                         bram_rd_addr,
  input  logic [PIXEL_BITS-1:0]                bram_rd_data,
  output logic [PIXEL_BITS-1:0]                highlight_din,
  output logic                                 highlight_wr_en,
  input  logic                                 highlight_full,
  output logic                                 busy,
  output logic                                 frame_done
`ifdef HIGHLIGHT_PIXEL_CNT_EN
  ,
  output logic [31:0]                          pixels_drawn
`endif
);

  localparam int LW   = $clog2(NUM_LANES + 1);
  localparam int LI_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LANE_SELECT,
    S_K_CALC,
    S_CHECK,
    S_PIXEL,
    S_OUTPUT,
    S_LAST
  } state_t;

  state_t state, state_next;

  // Control / counters (reset)
  logic [A:0]         clr_cnt;
  logic               pending;
  logic [LW-1:0]      lane_idx;
  logic signed [31:0] k;
  logic signed [15:0] off;
  logic [A-1:0]       ptr;
  logic               prime;

  // Datapath (not reset)
  logic [NUM_LANES-1:0][15:0]           lat_rho;
  logic [NUM_LANES-1:0][THETA_BITS-1:0] lat_theta;
  logic [NUM_LANES-1:0]                 lat_valid;
  logic [NUM_LANES-1:0][PIXEL_BITS-1:0] lat_color;
  logic signed [TRIG_DATA_SIZE-1:0]     cur_sin, cur_cos;
  logic signed [15:0]                   cur_rho;
  logic [PIXEL_BITS-1:0]                cur_color;
  logic signed [15:0]                   x, y;

  // Shift right by BITS truncating toward zero: negative values are
  // negated, shifted and negated back so -1.5 becomes -1, not -2.
  function automatic logic signed [15:0] dq(input logic signed [31:0] v);
    logic signed [31:0] mag;
    if (v < 0) begin
      mag = (-v) >>> BITS;
      return 16'(-mag);
    end
    return 16'(v >>> BITS);
  endfunction

  // Out-of-range theta reads as 0; such lanes are skipped anyway.
  function automatic logic signed [TRIG_DATA_SIZE-1:0] trig_lookup(
    input logic use_sin, input logic [THETA_BITS-1:0] th);
    logic [7:0] idx;
    idx = 8'(th);
    if (32'(th) > 179) return '0;
    if (use_sin) return SIN_QUANTIZED[idx];
    return COS_QUANTIZED[idx];
  endfunction

  logic               go;
  logic [LI_W-1:0]    li;
  logic               last_lane;
  logic               lane_go;
  logic signed [31:0] rho_w, sin_w, cos_w, prod_x, prod_y;
  logic signed [31:0] x_w, y_w, off_w;
  logic               k_done, in_frame, col_ok, off_end;
  logic [A-1:0]       pix_addr;

  assign go        = hough_done || pending;
  assign last_lane = (lane_idx == LW'(NUM_LANES));
  assign li        = last_lane ? '0 : LI_W'(lane_idx);
  assign lane_go   = lat_valid[li] && (32'(lat_theta[li]) <= 179);

  assign rho_w  = 32'(cur_rho);
  assign sin_w  = 32'(cur_sin);
  assign cos_w  = 32'(cur_cos);
  assign prod_x = rho_w * cos_w - k * sin_w;
  assign prod_y = rho_w * sin_w + k * cos_w;

  assign x_w   = 32'(x);
  assign y_w   = 32'(y);
  assign off_w = 32'(off);

  assign k_done   = (k >= K_END);
  assign in_frame = (y_w >= 0) && (y_w < HEIGHT) &&
                    (x_w + HALF_WIDTH >= 0) && (x_w - HALF_WIDTH < WIDTH);
  assign col_ok   = (off_w >= 0) && (off_w < WIDTH);
  assign off_end  = (off_w == x_w + HALF_WIDTH);
  assign pix_addr = A'(y_w * WIDTH + off_w);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_CLEAR;
    else          state <= state_next;
  end

  // Next state and combinational FIFO/read-port outputs. The read address
  // is the pointer value for the next cycle, so the BRAM's registered data
  // always lines up with the current pointer.
  always_comb begin
    state_next      = state;
    busy            = (state != S_IDLE);
    highlight_wr_en = 1'b0;
    highlight_din   = '0;
    frame_done      = 1'b0;
    bram_rd_addr    = '0;
    case (state)
      S_CLEAR:       if (clr_cnt == (A+1)'(NPIX)) state_next = S_IDLE;
      S_IDLE:        if (go) state_next = S_LANE_SELECT;
      S_LANE_SELECT: begin
        if (last_lane)    state_next = S_OUTPUT;
        else if (lane_go) state_next = S_K_CALC;
      end
      S_K_CALC:      state_next = k_done ? S_LANE_SELECT : S_CHECK;
      S_CHECK:       state_next = in_frame ? S_PIXEL : S_K_CALC;
      S_PIXEL:       if (off_end) state_next = S_K_CALC;
      S_OUTPUT: begin
        bram_rd_addr = ptr;
        if (!prime && !highlight_full) begin
          highlight_wr_en = 1'b1;
          highlight_din   = bram_rd_data;
          bram_rd_addr    = ptr + A'(1);
          if (ptr == A'(NPIX - 2)) state_next = S_LAST;
        end
      end
      S_LAST: begin
        bram_rd_addr = ptr;
        if (!highlight_full) begin
          highlight_wr_en = 1'b1;
          highlight_din   = bram_rd_data;
          frame_done      = 1'b1;
          state_next      = S_CLEAR;
        end
      end
      default: state_next = S_CLEAR;
    endcase
  end

  // Counters, pending flag and the registered frame write port. A write
  // issued in a state appears on the port one cycle later; CLEAR runs one
  // extra cycle so its final write lands while busy is still high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt      <= '0;
      pending      <= 1'b0;
      lane_idx     <= '0;
      k            <= '0;
      off          <= '0;
      ptr          <= '0;
      prime        <= 1'b0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
    end else begin
      bram_wr_en <= 1'b0;
      if (hough_done && state != S_IDLE) pending <= 1'b1;
      case (state)
        S_CLEAR: begin
          if (clr_cnt != (A+1)'(NPIX)) begin
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= A'(clr_cnt);
            bram_wr_data <= '0;
            clr_cnt      <= clr_cnt + (A+1)'(1);
          end
        end
        S_IDLE: begin
          if (go) begin
            pending  <= 1'b0;
            lane_idx <= '0;
          end
        end
        S_LANE_SELECT: begin
          if (last_lane) begin
            ptr   <= '0;
            prime <= 1'b1;
          end else if (lane_go) begin
            k <= K_START;
          end else begin
            lane_idx <= lane_idx + LW'(1);
          end
        end
        S_K_CALC: if (k_done) lane_idx <= lane_idx + LW'(1);
        S_CHECK: begin
          if (in_frame) off <= 16'(x_w - HALF_WIDTH);
          else          k   <= k + 32'sd1;
        end
        S_PIXEL: begin
          if (col_ok) begin
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= pix_addr;
            bram_wr_data <= cur_color;
          end
          if (off_end) k   <= k + 32'sd1;
          else         off <= off + 16'sd1;
        end
        S_OUTPUT: begin
          if (prime)                prime <= 1'b0;
          else if (!highlight_full) ptr   <= ptr + A'(1);
        end
        S_LAST: if (!highlight_full) clr_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Lane latch, per-lane trig/colour load and line-point evaluation
  always_ff @(posedge clock) begin
    if (state == S_IDLE && go) begin
      lat_rho   <= lane_rho;
      lat_theta <= lane_theta;
      lat_valid <= lane_valid;
      lat_color <= lane_color;
    end
    if (state == S_LANE_SELECT && !last_lane && lane_go) begin
      cur_sin   <= trig_lookup(1'b1, lat_theta[li]);
      cur_cos   <= trig_lookup(1'b0, lat_theta[li]);
      cur_rho   <= $signed(lat_rho[li]);
      cur_color <= lat_color[li];
    end
    if (state == S_K_CALC && !k_done) begin
      x <= dq(prod_x);
      y <= dq(prod_y);
    end
  end

`ifdef HIGHLIGHT_PIXEL_CNT_EN
  // Counts exactly the draw writes issued from PIXEL
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         pixels_drawn <= '0;
    else if (state == S_IDLE && go)       pixels_drawn <= '0;
    else if (state == S_PIXEL && col_ok)  pixels_drawn <= pixels_drawn + 32'd1;
  end
`else
  // No draw-write counter in this build.
`endif

endmodule

// File: tb/tb_highlight_multi.sv
module tb_highlight_multi;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int NP = W * H;

  localparam logic signed [11:0] SIN_T [0:179] =
    '{45: 12'sd181, 90: 12'sd256, 135: 12'sd181, default: 12'sd0};
  localparam logic signed [11:0] COS_T [0:179] =
    '{0: 12'sd256, 45: 12'sd181, 135: -12'sd181, default: 12'sd0};

  logic             clock = 1'b0;
  logic             reset_n;
  logic             hough_done;
  logic [1:0][15:0] lane_rho;
  logic [1:0][8:0]  lane_theta;
  logic [1:0]       lane_valid;
  logic [1:0][7:0]  lane_color;
  logic             bram_wr_en;
  logic [6:0]       bram_wr_addr, bram_rd_addr;
  logic [7:0]       bram_wr_data, bram_rd_data, highlight_din;
  logic             highlight_wr_en, highlight_full, busy, frame_done;

  always #5 clock = ~clock;

  highlight_multi #(
    .NUM_LANES(2), .WIDTH(W), .HEIGHT(H), .PIXEL_BITS(8), .THETA_BITS(9),
    .TRIG_DATA_SIZE(12), .BITS(8), .K_START(-8), .K_END(8), .HALF_WIDTH(1),
    .SIN_QUANTIZED(SIN_T), .COS_QUANTIZED(COS_T)
  ) dut (
    .clock(clock), .reset_n(reset_n), .hough_done(hough_done),
    .lane_rho(lane_rho), .lane_theta(lane_theta), .lane_valid(lane_valid),
    .lane_color(lane_color), .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data), .bram_rd_addr(bram_rd_addr),
    .bram_rd_data(bram_rd_data), .highlight_din(highlight_din),
    .highlight_wr_en(highlight_wr_en), .highlight_full(highlight_full),
    .busy(busy), .frame_done(frame_done)
  );

  // Frame BRAM with one-cycle read latency
  logic [7:0] mem [0:NP-1];
  always @(posedge clock) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
    bram_rd_data <= mem[bram_rd_addr];
  end

  // Downstream FIFO capture
  logic [7:0] fifo_q[$];
  int fd_cnt = 0;
  int wr_full_cnt = 0;
  always @(posedge clock) begin
    if (highlight_wr_en) fifo_q.push_back(highlight_din);
    if (frame_done) fd_cnt++;
    if (highlight_wr_en && highlight_full) wr_full_cnt++;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int last_base = 0;

  int m_rho[2], m_theta[2], m_color[2];
  bit m_valid[2];
  int exp_frame[NP];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each valid lane, in index order, paints a (2*1+1)-wide
  // horizontal run centred at x for every k whose y lands inside the frame.
  task automatic build_model();
    for (int p = 0; p < NP; p++) exp_frame[p] = 0;
    for (int l = 0; l < 2; l++) begin
      if (m_valid[l] && m_theta[l] >= 0 && m_theta[l] <= 179) begin
        int c, s;
        c = COS_T[m_theta[l]];
        s = SIN_T[m_theta[l]];
        for (int k = -8; k < 8; k++) begin
          int x, y;
          x = (m_rho[l] * c - k * s) / 256;
          y = (m_rho[l] * s + k * c) / 256;
          if (y >= 0 && y < H)
            for (int col = x - 1; col <= x + 1; col++)
              if (col >= 0 && col < W) exp_frame[y * W + col] = m_color[l];
        end
      end
    end
  endtask

  task automatic set_lane(input int l, input bit v, input int th, input int rho, input int col);
    m_valid[l] = v; m_theta[l] = th; m_rho[l] = rho; m_color[l] = col;
    lane_valid[l] = v;
    lane_theta[l] = 9'(th);
    lane_rho[l]   = 16'(rho);
    lane_color[l] = 8'(col);
  endtask

  task automatic pulse_done();
    hough_done = 1'b1;
    @(negedge clock);
    hough_done = 1'b0;
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    int idx;
    idx = last_base + r * W + c;
    if (idx < fifo_q.size()) return fifo_q[idx];
    return 8'hxx;
  endfunction

  task automatic clear_check(input string tag);
    int n = 0;
    int bad = 0;
    bit idle = 0;
    for (int i = 0; i < 1000 && !idle; i++) begin
      @(negedge clock);
      if (!busy) idle = 1;
      else if (bram_wr_en) begin
        if (bram_wr_addr !== 7'(n) || bram_wr_data !== 8'h00) bad++;
        n++;
      end
    end
    check({tag, " reached idle"}, idle, 1);
    check({tag, " clear writes"}, n, NP);
    check({tag, " clear addr/data"}, bad, 0);
    check({tag, " busy low"}, busy, 0);
  endtask

  task automatic collect(input string tag, input bit rand_full, input bit scramble,
                         input bit wait_idle);
    int base, fd0, wf0, mism, first, got;
    bit done, idle;
    base = fifo_q.size(); fd0 = fd_cnt; wf0 = wr_full_cnt;
    mism = 0; first = -1; done = 0; idle = 0;
    last_base = base;
    build_model();
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clock);
      if (scramble && i == 0) begin
        lane_rho   = 32'($urandom);
        lane_theta = 18'($urandom);
        lane_valid = 2'($urandom);
        lane_color = 16'($urandom);
      end
      highlight_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
      if (fd_cnt != fd0) done = 1;
    end
    highlight_full = 1'b0;
    check({tag, " frame_done seen"}, done, 1);
    got = fifo_q.size() - base;
    check({tag, " pixel count"}, got, NP);
    for (int p = 0; p < NP; p++) begin
      logic [7:0] v;
      v = (base + p < fifo_q.size()) ? fifo_q[base + p] : 8'hxx;
      if (v !== 8'(exp_frame[p])) begin
        mism++;
        if (first < 0) first = p;
      end
    end
    check($sformatf("%s pixels (first bad index %0d)", tag, first), mism, 0);
    check({tag, " no write while full"}, wr_full_cnt - wf0, 0);
    if (wait_idle) begin
      for (int i = 0; i < 400 && !idle; i++) begin
        @(negedge clock);
        if (!busy) idle = 1;
      end
      check({tag, " back to idle"}, idle, 1);
      check({tag, " single frame_done"}, fd_cnt - fd0, 1);
    end
  endtask

  initial begin
    int th_opts[6];
    bit found;
    th_opts = '{0, 45, 90, 135, 179, 200};
    reset_n = 1'b0;
    hough_done = 1'b0;
    highlight_full = 1'b0;
    lane_rho = '0; lane_theta = '0; lane_valid = '0; lane_color = '0;
    repeat (3) @(negedge clock);

    // Reset state
    check("reset busy", busy, 1);
    check("reset bram_wr_en", bram_wr_en, 0);
    check("reset bram_wr_addr", bram_wr_addr, 0);
    check("reset bram_rd_addr", bram_rd_addr, 0);
    check("reset highlight_wr_en", highlight_wr_en, 0);
    check("reset frame_done", frame_done, 0);

    // 1: clear after reset release
    reset_n = 1'b1;
    clear_check("t1");

    // 2: single lane, vertical stripe at columns 4..6
    set_lane(0, 1, 0, 5, 8'hFF);
    set_lane(1, 0, 0, 9, 8'h77);
    pulse_done();
    collect("t2", 0, 1, 1);
    check("t2 pix(2,4)", pix(2, 4), 8'hFF);
    check("t2 pix(6,6)", pix(6, 6), 8'hFF);
    check("t2 pix(3,7)", pix(3, 7), 8'h00);
    check("t2 pix(0,3)", pix(0, 3), 8'h00);

    // 3: overlap, higher lane wins
    set_lane(0, 1, 0, 5, 8'h11);
    set_lane(1, 1, 0, 6, 8'h22);
    pulse_done();
    collect("t3", 0, 1, 1);
    check("t3 pix(0,4)", pix(0, 4), 8'h11);
    check("t3 pix(3,5)", pix(3, 5), 8'h22);
    check("t3 pix(7,7)", pix(7, 7), 8'h22);
    check("t3 pix(5,8)", pix(5, 8), 8'h00);

    // 4: line on the left edge, column -1 suppressed
    set_lane(0, 1, 0, 0, 8'h33);
    set_lane(1, 0, 0, 0, 8'h44);
    pulse_done();
    collect("t4", 0, 1, 1);
    check("t4 pix(4,0)", pix(4, 0), 8'h33);
    check("t4 pix(7,1)", pix(7, 1), 8'h33);
    check("t4 pix(4,15)", pix(4, 15), 8'h00);
    check("t4 pix(0,15)", pix(0, 15), 8'h00);

    // 5: random lanes with random FIFO back-pressure
    for (int it = 0; it < 4; it++) begin
      for (int l = 0; l < 2; l++)
        set_lane(l, 1'($urandom_range(0, 3) != 0), th_opts[$urandom_range(0, 5)],
                 int'($urandom_range(0, 40)) - 10, int'($urandom_range(1, 255)));
      pulse_done();
      collect($sformatf("t5.%0d", it), 1, 1, it != 3);
    end

    // 6a: hough_done pulses during CLEAR collapse into one pending frame
    check("t6a busy in clear", busy, 1);
    set_lane(0, 1, 45, 12, 8'h5A);
    set_lane(1, 1, 90, 3, 8'hA5);
    pulse_done();
    @(negedge clock);
    pulse_done();
    collect("t6a", 0, 0, 1);
    repeat (20) @(negedge clock);
    check("t6a no extra frame", busy, 0);

    // 6b: asynchronous reset while drawing
    set_lane(0, 1, 0, 5, 8'hFF);
    set_lane(1, 0, 0, 0, 8'h00);
    pulse_done();
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clock);
      if (bram_wr_en && bram_wr_data == 8'hFF) found = 1;
    end
    check("t6b draw write seen", found, 1);
    reset_n = 1'b0;
    #1;
    check("t6b async busy", busy, 1);
    check("t6b async bram_wr_en", bram_wr_en, 0);
    check("t6b async bram_wr_data", bram_wr_data, 0);
    check("t6b async highlight_wr_en", highlight_wr_en, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clear_check("t6b");
    repeat (20) @(negedge clock);
    check("t6b stays idle", busy, 0);
    pulse_done();
    collect("t6b redraw", 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
